// File: rtl/ram_arbiter_pkg.sv
// Shared definitions for the RAM arbiter: data-path width, fetch-port
// geometry and the encoding of the registered response-owner state.
package ram_arbiter_pkg;

    localparam int WIDTH = 16;  // data port and RAM word/address width
    localparam int IF_AW = 13;  // fetch address (pc) width
    localparam int IF_DW = 16;  // fetched instruction width

    // Which requester owns the RAM response arriving this cycle.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D_RD = 2'd2,
        OWN_D_WR = 2'd3
    } owner_e;

    // Zero-extend a fetch address onto the RAM address bus.
    function automatic logic [WIDTH-1:0] fetch_addr(input logic [IF_AW-1:0] pc);
        return {{(WIDTH-IF_AW){1'b0}}, pc};
    endfunction

endpackage

// File: rtl/ram_arbiter.sv
// Single-port RAM arbiter between an instruction-fetch port and a data port.
// Grants and the RAM strobe are combinational from the requests and the
// starvation counter; the response of each access is routed one cycle later
// using the registered owner state. The data port normally wins, but a fetch
// that has lost STARVE_MAX cycles in a row is forced through.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_req,
    input  logic [IF_AW-1:0] if_addr,
    output logic             if_gnt,
    output logic             if_valid,
    output logic [IF_DW-1:0] if_data,
    input  logic             d_req,
    input  logic             d_we,
    input  logic [WIDTH-1:0] d_addr,
    input  logic [WIDTH-1:0] d_wdata,
    output logic             d_gnt,
    output logic             d_valid,
    output logic [WIDTH-1:0] d_rdata,
    output logic             mem_en,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata
);

    localparam int             CW         = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0]  STARVE_LIM = CW'(STARVE_MAX);
    localparam logic [CW-1:0]  STARVE_ONE = CW'(1);

    owner_e          owner_r;
    owner_e          owner_s;
    logic [CW-1:0]   starve_cnt_r;
    logic [CW-1:0]   starve_cnt_s;

    logic            if_gnt_s;
    logic            d_gnt_s;
    logic            mem_en_s;
    logic            mem_we_s;
    logic [WIDTH-1:0] mem_addr_s;
    logic [WIDTH-1:0] mem_wdata_s;

    logic            if_valid_s;
    logic [IF_DW-1:0] if_data_s;
    logic            d_valid_s;
    logic [WIDTH-1:0] d_rdata_s;

    // Owner and starvation-counter state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_r      <= OWN_NONE;
            starve_cnt_r <= {CW{1'b0}};
        end else begin
            owner_r      <= owner_s;
            starve_cnt_r <= starve_cnt_s;
        end
    end

    // Arbitration, RAM request mux and next owner / starvation count.
    always_comb begin
        if_gnt_s     = 1'b0;
        d_gnt_s      = 1'b0;
        mem_en_s     = 1'b0;
        mem_we_s     = 1'b0;
        mem_addr_s   = {WIDTH{1'b0}};
        mem_wdata_s  = {WIDTH{1'b0}};
        owner_s      = OWN_NONE;
        starve_cnt_s = {CW{1'b0}};

        if (rst) begin
            // Nothing is granted while in reset, so nothing can return later.
            owner_s = OWN_NONE;
        end else begin
            if (if_req && d_req) begin
                if (starve_cnt_r == STARVE_LIM) begin
                    if_gnt_s = 1'b1;
                end else begin
                    d_gnt_s = 1'b1;
                end
            end else if (if_req) begin
                if_gnt_s = 1'b1;
            end else if (d_req) begin
                d_gnt_s = 1'b1;
            end else begin
                if_gnt_s = 1'b0;
            end

            if (if_gnt_s) begin
                mem_en_s   = 1'b1;
                mem_addr_s = fetch_addr(if_addr);
                owner_s    = OWN_IF;
            end else if (d_gnt_s) begin
                mem_en_s    = 1'b1;
                mem_we_s    = d_we;
                mem_addr_s  = d_addr;
                mem_wdata_s = d_wdata;
                owner_s     = d_we ? OWN_D_WR : OWN_D_RD;
            end else begin
                owner_s = OWN_NONE;
            end

            // Count only cycles in which a pending fetch lost; saturate.
            if (if_req && !if_gnt_s) begin
                if (starve_cnt_r == STARVE_LIM) begin
                    starve_cnt_s = starve_cnt_r;
                end else begin
                    starve_cnt_s = starve_cnt_r + STARVE_ONE;
                end
            end else begin
                starve_cnt_s = {CW{1'b0}};
            end
        end
    end

    // Route the RAM response to the port that owned last cycle's access.
    always_comb begin
        if_valid_s = 1'b0;
        if_data_s  = {IF_DW{1'b0}};
        d_valid_s  = 1'b0;
        d_rdata_s  = {WIDTH{1'b0}};

        if (rst) begin
            // A response due during reset is dropped; the requester retries.
            if_valid_s = 1'b0;
        end else begin
            case (owner_r)
                OWN_IF: begin
                    if_valid_s = 1'b1;
                    if_data_s  = mem_rdata[IF_DW-1:0];
                end
                OWN_D_RD: begin
                    d_valid_s = 1'b1;
                    d_rdata_s = mem_rdata;
                end
                OWN_D_WR: begin
                    d_valid_s = 1'b1;
                end
                default: begin
                    if_valid_s = 1'b0;
                end
            endcase
        end
    end

    assign if_gnt    = if_gnt_s;
    assign d_gnt     = d_gnt_s;
    assign mem_en    = mem_en_s;
    assign mem_we    = mem_we_s;
    assign mem_addr  = mem_addr_s;
    assign mem_wdata = mem_wdata_s;
    assign if_valid  = if_valid_s;
    assign if_data   = if_data_s;
    assign d_valid   = d_valid_s;
    assign d_rdata   = d_rdata_s;

endmodule
